// File: rtl/taint_sum_scanner_if.sv
// Control, sample and report bundle for taint_sum_scanner.
// rpt_first_cyc exists only when TAINT_SCAN_STAMP_EN is defined.
interface taint_sum_scanner_if #(
    parameter int NUM_SRC = 16,
    parameter int CNT_W   = 16,
    parameter int WIN_W   = 16
);
    localparam int PCW  = $clog2(NUM_SRC + 1);
    localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic               start;
    logic               cont;
    logic [WIN_W-1:0]   window_len;
    logic [CNT_W-1:0]   threshold;
    logic [NUM_SRC-1:0] taint_sum_in;
    logic               busy;
    logic               rpt_valid;
    logic               rpt_ready;
    logic [CNT_W-1:0]   rpt_count;
    logic [PCW-1:0]     rpt_peak;
    logic               rpt_first_vld;
    logic [IDXW-1:0]    rpt_first_idx;
    logic               alarm;
`ifdef TAINT_SCAN_STAMP_EN
    logic [WIN_W-1:0]   rpt_first_cyc;

    modport master (
        output start, cont, window_len, threshold, taint_sum_in, rpt_ready,
        input  busy, rpt_valid, rpt_count, rpt_peak, rpt_first_vld, rpt_first_idx, alarm,
               rpt_first_cyc
    );
    modport slave (
        input  start, cont, window_len, threshold, taint_sum_in, rpt_ready,
        output busy, rpt_valid, rpt_count, rpt_peak, rpt_first_vld, rpt_first_idx, alarm,
               rpt_first_cyc
    );
`else
    modport master (
        output start, cont, window_len, threshold, taint_sum_in, rpt_ready,
        input  busy, rpt_valid, rpt_count, rpt_peak, rpt_first_vld, rpt_first_idx, alarm
    );
    modport slave (
        input  start, cont, window_len, threshold, taint_sum_in, rpt_ready,
        output busy, rpt_valid, rpt_count, rpt_peak, rpt_first_vld, rpt_first_idx, alarm
    );
`endif
endinterface

// File: rtl/taint_sum_scanner.sv
// Windowed popcount monitor for taint_sum bits: per-window total, peak, first source, sticky alarm.
// Define TAINT_SCAN_STAMP_EN to add rpt_first_cyc (sample index of the first tainted cycle).
module taint_sum_scanner #(
    parameter int NUM_SRC = 16,
    parameter int CNT_W   = 16,
    parameter int WIN_W   = 16
) (
    input  logic clock,
    input  logic reset_n,
    taint_sum_scanner_if.slave bus
);
    localparam int PCW  = $clog2(NUM_SRC + 1);
    localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int SUMW = ((CNT_W > PCW) ? CNT_W : PCW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t             state;
    logic [WIN_W-1:0]   win_len;
    logic [WIN_W-1:0]   win_cnt;
    logic [CNT_W-1:0]   count;
    logic [PCW-1:0]     peak;
    logic               first_vld;
    logic [IDXW-1:0]    first_idx;
    logic               alarm;
    logic               busy;
    logic               rpt_valid;
`ifdef TAINT_SCAN_STAMP_EN
    logic [WIN_W-1:0]   first_cyc;
`endif

    // Anything that is not a solid 1 (X/Z from uninitialised cells) counts as untainted.
    function automatic logic [NUM_SRC-1:0] sanitise(input logic [NUM_SRC-1:0] v);
        logic [NUM_SRC-1:0] s;
        for (int i = 0; i < NUM_SRC; i++)
            s[i] = (v[i] === 1'b1);
        return s;
    endfunction

    function automatic logic [PCW-1:0] popcount(input logic [NUM_SRC-1:0] v);
        logic [PCW-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (v[i]) n = n + PCW'(1);
        return n;
    endfunction

    function automatic logic [IDXW-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (v[i]) idx = IDXW'(i);
        return idx;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [PCW-1:0] b);
        logic [SUMW-1:0] s;
        s = SUMW'(a) + SUMW'(b);
        return (s > SUMW'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    logic [NUM_SRC-1:0] taint;
    logic [PCW-1:0]     pc;
    logic [CNT_W-1:0]   count_nxt;
    logic [WIN_W-1:0]   len_in;
    logic               new_win;
    logic               clr_alarm;
    logic               last_sample;

    always_comb begin
        taint       = sanitise(bus.taint_sum_in);
        pc          = popcount(taint);
        count_nxt   = sat_add(count, pc);
        len_in      = (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
        // start restarts from IDLE or SCAN; an accepted report with cont re-arms without touching alarm
        clr_alarm   = bus.start && (state != REPORT);
        new_win     = clr_alarm || ((state == REPORT) && bus.rpt_ready && bus.cont);
        last_sample = (win_cnt == win_len - WIN_W'(1));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            win_len   <= '0;
            win_cnt   <= '0;
            count     <= '0;
            peak      <= '0;
            first_vld <= 1'b0;
            first_idx <= '0;
            alarm     <= 1'b0;
            busy      <= 1'b0;
            rpt_valid <= 1'b0;
`ifdef TAINT_SCAN_STAMP_EN
            first_cyc <= '0;
`endif
        end else if (new_win) begin
            state     <= SCAN;
            busy      <= 1'b1;
            rpt_valid <= 1'b0;
            win_len   <= len_in;
            win_cnt   <= '0;
            count     <= '0;
            peak      <= '0;
            first_vld <= 1'b0;
            first_idx <= '0;
            if (clr_alarm) alarm <= 1'b0;
`ifdef TAINT_SCAN_STAMP_EN
            first_cyc <= '0;
`endif
        end else begin
            case (state)
                SCAN: begin
                    count   <= count_nxt;
                    win_cnt <= win_cnt + WIN_W'(1);
                    if (pc > peak) peak <= pc;
                    if (!first_vld && (pc != '0)) begin
                        first_vld <= 1'b1;
                        first_idx <= lowest_idx(taint);
`ifdef TAINT_SCAN_STAMP_EN
                        first_cyc <= win_cnt;
`endif
                    end
                    if ((bus.threshold != '0) && (count_nxt >= bus.threshold)) alarm <= 1'b1;
                    if (last_sample) begin
                        state     <= REPORT;
                        rpt_valid <= 1'b1;
                    end
                end
                REPORT: begin
                    if (bus.rpt_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        rpt_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy          = busy;
    assign bus.rpt_valid     = rpt_valid;
    assign bus.rpt_count     = count;
    assign bus.rpt_peak      = peak;
    assign bus.rpt_first_vld = first_vld;
    assign bus.rpt_first_idx = first_idx;
    assign bus.alarm         = alarm;
`ifdef TAINT_SCAN_STAMP_EN
    assign bus.rpt_first_cyc = first_cyc;
`endif
endmodule

// File: tb/tb_taint_sum_scanner.sv
// Randomized bench for taint_sum_scanner against a window-level model built from sample queues;
// rpt_first_cyc is also checked when TAINT_SCAN_STAMP_EN is defined.
module tb_taint_sum_scanner;
    localparam int NUM_SRC = 16;
    localparam int CNT_W   = 16;
    localparam int WIN_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    taint_sum_scanner_if #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    taint_sum_scanner #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state for the current window
    int m_L, m_thr, m_cnt, m_peak, m_idx, m_fidx, m_fcyc;
    bit m_fvld, m_alarm, m_cont;
    logic [15:0] pat[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int ones(input logic [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) if (v[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int low(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i] === 1'b1) return i;
        return 0;
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] v;
        int k;
        v = 16'($urandom);
        k = $urandom_range(0, 15);
        case ($urandom_range(0, 4))
            0: v = 16'h0000;
            1: v = 16'h0001 << k;
            2: v = v & 16'($urandom) & 16'($urandom);
            3: v[k] = 1'bx;
            default: ;
        endcase
        return v;
    endfunction

    task automatic clear_model();
        m_cnt = 0; m_peak = 0; m_fvld = 0; m_fidx = 0; m_fcyc = 0; m_idx = 0;
    endtask

    task automatic begin_window(input int len, input int thr, input bit c);
        bus.window_len = WIN_W'(len);
        bus.threshold  = CNT_W'(thr);
        bus.cont       = c;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        m_L = (len == 0) ? 1 : len;
        m_thr = thr;
        m_alarm = 0;
        clear_model();
        check("start_busy", bus.busy, 1);
        check("start_valid", bus.rpt_valid, 0);
        check("start_alarm", bus.alarm, 0);
    endtask

    task automatic feed(input int n);
        logic [15:0] v;
        int p;
        for (int k = 0; k < n; k++) begin
            v = pat.pop_front();
            bus.taint_sum_in = v;
            step();
            p = ones(v);
            m_cnt = (m_cnt + p > CNT_MAX) ? CNT_MAX : m_cnt + p;
            if (p > m_peak) m_peak = p;
            if (!m_fvld && p != 0) begin
                m_fvld = 1; m_fidx = low(v); m_fcyc = m_idx;
            end
            m_idx++;
            if (m_thr != 0 && m_cnt >= m_thr) m_alarm = 1;
            check("sample_alarm", bus.alarm, m_alarm);
            check("sample_valid", bus.rpt_valid, (m_idx == m_L));
        end
    endtask

    task automatic check_report();
        check("rpt_valid", bus.rpt_valid, 1);
        check("rpt_busy", bus.busy, 1);
        check("rpt_count", bus.rpt_count, m_cnt);
        check("rpt_peak", bus.rpt_peak, m_peak);
        check("rpt_first_vld", bus.rpt_first_vld, m_fvld);
        check("rpt_first_idx", bus.rpt_first_idx, m_fidx);
        check("rpt_alarm", bus.alarm, m_alarm);
`ifdef TAINT_SCAN_STAMP_EN
        check("rpt_first_cyc", bus.rpt_first_cyc, m_fcyc);
`endif
    endtask

    // Stall for 'delay' cycles with live noise on the sample bus, then accept the report.
    task automatic handshake(input int delay, input bit start_in_rpt);
        for (int d = 0; d < delay; d++) begin
            bus.rpt_ready    = 1'b0;
            bus.taint_sum_in = 16'($urandom);
            bus.start        = start_in_rpt && (d == 0);
            step();
            bus.start = 1'b0;
            check_report();
        end
        m_cont = bus.cont;
        bus.rpt_ready = 1'b1;
        step();
        bus.rpt_ready = 1'b0;
        check("hs_valid", bus.rpt_valid, 0);
        check("hs_busy", bus.busy, m_cont);
        check("hs_alarm", bus.alarm, m_alarm);
        if (m_cont) begin
            m_L = (bus.window_len == 0) ? 1 : int'(bus.window_len);
            clear_model();
        end
    endtask

    initial begin
        int len;
        bus.start = 0; bus.cont = 0; bus.window_len = 0; bus.threshold = 0;
        bus.taint_sum_in = 0; bus.rpt_ready = 0;
        repeat (3) step();
        check("reset_busy", bus.busy, 0);
        check("reset_valid", bus.rpt_valid, 0);
        check("reset_count", bus.rpt_count, 0);
        check("reset_peak", bus.rpt_peak, 0);
        check("reset_first", bus.rpt_first_vld, 0);
        check("reset_alarm", bus.alarm, 0);
        @(negedge clock) reset_n = 1'b1;
        step();

        // quiet window: report exactly L+1 cycles after start
        begin_window(4, 0, 0);
        repeat (4) pat.push_back(16'h0000);
        feed(4);
        check_report();
        check("quiet_count", bus.rpt_count, 0);
        handshake(0, 0);

        // mixed window
        begin_window(3, 0, 0);
        pat.push_back(16'h0000); pat.push_back(16'h0014); pat.push_back(16'h00FF);
        feed(3);
        check_report();
        check("mix_count", bus.rpt_count, 10);
        check("mix_peak", bus.rpt_peak, 8);
        check("mix_first_idx", bus.rpt_first_idx, 2);
`ifdef TAINT_SCAN_STAMP_EN
        check("mix_first_cyc", bus.rpt_first_cyc, 1);
`endif
        handshake(1, 0);

        // threshold crossing on the 2nd sample, alarm sticks after the report
        begin_window(4, 5, 0);
        repeat (4) pat.push_back(16'h000F);
        feed(4);
        check_report();
        check("thr_count", bus.rpt_count, 16);
        handshake(2, 0);
        step();
        check("thr_alarm_idle", bus.alarm, 1);

        // long all-ones window saturates the count; threshold 0 keeps alarm off
        begin_window(5000, 0, 0);
        repeat (5000) pat.push_back(16'hFFFF);
        feed(5000);
        check_report();
        check("sat_count", bus.rpt_count, CNT_MAX);
        check("sat_peak", bus.rpt_peak, 16);
        handshake(0, 0);

        // window_len 0 behaves as a single sample
        begin_window(0, 0, 0);
        pat.push_back(16'h8000);
        feed(1);
        check_report();
        check("len0_first_idx", bus.rpt_first_idx, 15);
        handshake(1, 0);

        // continuous mode: random windows, stalls, start during REPORT, alarm kept across windows
        begin_window($urandom_range(0, 8), $urandom_range(1, 40), 1);
        for (int w = 0; w < 14; w++) begin
            for (int k = 0; k < m_L; k++) pat.push_back(rand_word());
            feed(m_L);
            check_report();
            bus.window_len = WIN_W'($urandom_range(0, 8));
            if (w == 13) bus.cont = 1'b0;
            if (w % 3 == 0) handshake(3, 1);
            else handshake($urandom_range(0, 3), 0);
        end

        // start while scanning restarts the window and clears the alarm
        begin_window(6, 3, 0);
        repeat (3) pat.push_back(16'hFFFF);
        feed(3);
        check("restart_pre_alarm", bus.alarm, 1);
        begin_window(2, 0, 0);
        repeat (2) pat.push_back(rand_word());
        feed(2);
        check_report();
        handshake(0, 0);

        // asynchronous reset mid-window
        begin_window(10, 2, 0);
        repeat (3) pat.push_back(16'hFFFF);
        feed(3);
        #2 reset_n = 1'b0;
        #1;
        check("areset_busy", bus.busy, 0);
        check("areset_valid", bus.rpt_valid, 0);
        check("areset_alarm", bus.alarm, 0);
        check("areset_count", bus.rpt_count, 0);
        check("areset_peak", bus.rpt_peak, 0);
        step();
        @(negedge clock) reset_n = 1'b1;
        step();
        len = $urandom_range(1, 6);
        begin_window(len, 0, 0);
        repeat (len) pat.push_back(rand_word());
        feed(len);
        check_report();
        handshake(1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
